// File: rtl/cordic_mux_pkg.sv
// cordic_mux_pkg: shared state encoding and select constants for the skid-buffered mux
package cordic_mux_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;
    localparam int SEL_ZERO = 0;
endpackage

// File: rtl/mux_nx1_comb.sv
// mux_nx1_comb: select decode, code 0 gives zero, codes 1..CH pick a channel, higher codes flag an error
module mux_nx1_comb
    import cordic_mux_pkg::*;
#(
    parameter int W  = 32,
    parameter int CH = 3,
    parameter int SW = $clog2(CH + 1)
) (
    input  logic [SW-1:0]   select,
    input  logic [CH*W-1:0] ch_data,
    output logic [W-1:0]    word,
    output logic            err
);
    always_comb begin
        word = '0;
        err  = int'(select) > CH;
        for (int k = 0; k < CH; k++)
            if (int'(select) == SEL_ZERO + k + 1) word = ch_data[k*W +: W];
    end
endmodule

// File: rtl/mux_nx1_skid.sv
// mux_nx1_skid: N-to-1 registered mux with a two-entry skid buffer on a valid/ready stream
module mux_nx1_skid
    import cordic_mux_pkg::*;
#(
    parameter int W  = 32,
    parameter int CH = 3,
    parameter int SW = $clog2(CH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW-1:0]   select,
    input  logic [CH*W-1:0] ch_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [W-1:0]    data_out,
    output logic [SW-1:0]   sel_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            err_out
);
    localparam int BW = W + SW + 1;
    state_e        state_q, state_d;
    logic [BW-1:0] main_q, main_d, skid_q, skid_d, beat;
    logic [W-1:0]  word;
    logic          err, in_ready_q, acc, con;
    mux_nx1_comb #(.W(W), .CH(CH), .SW(SW)) u_comb (
        .select (select),
        .ch_data(ch_data),
        .word   (word),
        .err    (err)
    );
    assign beat                        = {err, select, word};
    assign {err_out, sel_out, data_out} = main_q;
    assign out_valid                   = state_q == ONE || state_q == FULL;
    assign in_ready                    = in_ready_q;
    assign acc                         = in_valid && in_ready_q;
    assign con                         = out_valid && out_ready;
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (acc) begin state_d = ONE; main_d = beat; end
            ONE: begin
                if (acc && con) main_d = beat;
                else if (acc) begin state_d = FULL; skid_d = beat; end
                else if (con) state_d = EMPTY;
            end
            FULL: if (con) begin state_d = ONE; main_d = skid_q; end
            default: state_d = EMPTY;
        endcase
    end
    // in_ready is registered from the next state, so out_ready never reaches it combinationally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= state_d != FULL;
        end
    end
endmodule

// File: tb/tb_mux_nx1_skid.sv
// tb_mux_nx1_skid: randomized scoreboard bench for mux_nx1_skid (W=32, CH=5 so codes 6..7 are out of range)
module tb_mux_nx1_skid;
    localparam int W  = 32;
    localparam int CH = 5;
    localparam int SW = $clog2(CH + 1);

    logic            clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [SW-1:0]   select = '0;
    logic [W-1:0]    ch [CH];
    logic [CH*W-1:0] ch_data;
    logic            in_ready, out_valid, err_out;
    logic [W-1:0]    data_out;
    logic [SW-1:0]   sel_out;

    int              n_chk = 0, n_fail = 0, n_out = 0, base;
    logic [W+SW:0]   exp_q [$];
    logic            hold_pending = 0;
    logic [W+SW:0]   held;
    logic [W-1:0]    sweep_exp [4] = '{32'h0, 32'hA5A5A5A5, 32'h12345678, 32'hDEADBEEF};

    mux_nx1_skid #(.W(W), .CH(CH)) dut (
        .clk      (clk),
        .rst      (rst),
        .select   (select),
        .ch_data  (ch_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_out (data_out),
        .sel_out  (sel_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_out  (err_out)
    );

    always #5 clk = ~clk;

    always_comb begin
        ch_data = '0;
        for (int i = 0; i < CH; i++) ch_data[i*W +: W] = ch[i];
    end

    function automatic logic [W+SW:0] model(input int s);
        if (s == 0) return '0;
        if (s <= CH) return {1'b0, SW'(s), ch[s-1]};
        return {1'b1, SW'(s), W'(0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // inputs are stable at the falling edge, so a handshake seen here completes on the next rising edge
    always @(negedge clk)
        if (rst && in_valid && in_ready) exp_q.push_back(model(int'(select)));

    always @(negedge clk) begin
        if (rst) begin
            if (hold_pending)
                check("hold_stable", {out_valid, err_out, sel_out, data_out}, {1'b1, held});
            hold_pending = out_valid && !out_ready;
            held         = {err_out, sel_out, data_out};
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h expected no beat", {err_out, sel_out, data_out});
                end else
                    check("beat", {err_out, sel_out, data_out}, exp_q.pop_front());
            end
        end
    end

    initial begin
        foreach (ch[i]) ch[i] = '0;
        #1 rst = 0;
        #1 check("reset_outputs", {in_ready, out_valid, err_out, sel_out, data_out}, 0);
        ch[0]    = 32'h11111111;
        select   = 1;
        in_valid = 1;
        #10 rst = 1;
        @(posedge clk); #1;
        check("ready_after_release", in_ready, 1);
        check("no_accept_on_release_edge", out_valid, 0);
        @(posedge clk); #1;
        check("first_beat_latency", {out_valid, data_out}, {1'b1, 32'h11111111});
        in_valid  = 0;
        out_ready = 1;
        @(posedge clk); #1;

        ch[0] = 32'hA5A5A5A5; ch[1] = 32'h12345678; ch[2] = 32'hDEADBEEF;
        ch[3] = $urandom; ch[4] = $urandom;
        in_valid = 1;
        for (int s = 0; s < 4; s++) begin
            select = SW'(s);
            @(posedge clk); #1;
            check("sweep", {out_valid, err_out, sel_out, data_out}, {1'b1, 1'b0, SW'(s), sweep_exp[s]});
        end
        for (int s = 6; s < 8; s++) begin
            select = SW'(s);
            @(posedge clk); #1;
            check("out_of_range", {err_out, sel_out, data_out}, {1'b1, SW'(s), W'(0)});
        end
        in_valid = 0;
        @(posedge clk); #1;
        check("empty_after_sweep", out_valid, 0);

        foreach (ch[i]) ch[i] = $urandom;
        out_ready = 0;
        select    = 1;
        in_valid  = 1;
        @(posedge clk); #1;
        check("bp_one_ready", in_ready, 1);
        select = 2;
        @(posedge clk); #1;
        check("bp_full_ready", in_ready, 0);
        check("bp_head", {out_valid, data_out}, {1'b1, ch[0]});
        select = 3;
        @(posedge clk); #1;
        check("bp_third_blocked", {in_ready, data_out}, {1'b0, ch[0]});
        in_valid  = 0;
        out_ready = 1;
        @(posedge clk); #1;
        check("bp_second", {out_valid, in_ready, data_out}, {2'b11, ch[1]});
        @(posedge clk); #1;
        check("bp_drained", out_valid, 0);

        base     = n_out;
        in_valid = 1;
        for (int i = 0; i < 100; i++) begin
            select = SW'($urandom_range(0, 7));
            foreach (ch[j]) ch[j] = $urandom;
            @(posedge clk); #1;
            check("stream_ready", in_ready, 1);
            check("stream_valid", out_valid, 1);
        end
        in_valid = 0;
        @(posedge clk); #1;
        check("stream_count", n_out - base, 100);

        out_ready = 0;
        select    = 4;
        in_valid  = 1;
        @(posedge clk); #1;
        select = 5;
        @(posedge clk); #1;
        in_valid = 0;
        check("pre_reset_full", {out_valid, in_ready}, 2'b10);
        #2 rst = 0;
        #1 check("async_reset", {in_ready, out_valid, err_out, sel_out, data_out}, 0);
        exp_q.delete();
        hold_pending = 0;
        rst          = 1;
        out_ready    = 1;
        @(posedge clk); #1;
        check("ready_after_midreset", {in_ready, out_valid}, 2'b10);
        repeat (3) @(posedge clk);
        #1 check("no_stale_beat", out_valid, 0);

        select   = 3;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1 check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
